stride_perm_bank: RTL and testbench

STRIDE_PERM_BANK -- requirements
Module: stride_perm_bank

---
 rtl/stride_perm_bank.sv | 160 ++++++++++++++++
 tb/tb_stride_perm_bank.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stride_perm_bank.sv
// rtl/stride_perm_bank.sv - ping-pong frame buffer applying pass-through, stride or bit-reverse permutation
module stride_perm_bank #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int FRAME_LEN    = 64
) (
  input  logic                               clk,
  input  logic                               rst_in,
  input  logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] in_data,
  input  logic                               ctrl_in,
  input  logic [1:0]                         mode_in,
  input  logic                               err_clr,
  output logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] out_data,
  output logic                               ctrl_out,
  output logic                               out_valid,
  output logic                               frame_err
);

  // One complex point (x in upper half, y in lower half)
  localparam int LW    = 2 * DATA_WIDTH;
  localparam int B     = FRAME_LEN / NUM_CHANNELS;
  localparam int LOG_F = $clog2(FRAME_LEN);
  localparam int CW    = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(B - 1);

  // Source point index for output point q under the given mode
  function automatic logic [LOG_F-1:0] perm_addr(input logic [1:0] mode, input logic [LOG_F-1:0] q);
    logic [LOG_F-1:0] r;
    r = q;
    case (mode)
      2'd1: r = LOG_F'(((int'(q) % B) * NUM_CHANNELS) + (int'(q) / B));
      2'd2: for (int i = 0; i < LOG_F; i++) r[i] = q[LOG_F-1-i];
      default: r = q;
    endcase
    return r;
  endfunction

  // Two frame buffers; contents are never reset
  logic [LW-1:0] r_mem [2][FRAME_LEN];

  // Write side state
  logic          r_wactive;
  logic [CW-1:0] r_wcnt;
  logic [1:0]    r_wmode;
  logic          r_wsel;

  // Read side state
  logic          r_ractive;
  logic [CW-1:0] r_rcnt;
  logic [1:0]    r_rmode;
  logic          r_rsel;

  logic          w_beat;
  logic          w_last;
  logic [CW-1:0] w_idx;
  logic [1:0]    w_mode;
  logic [LOG_F-1:0] w_waddr [NUM_CHANNELS];
  logic [LOG_F-1:0] w_raddr [NUM_CHANNELS];
  logic [NUM_CHANNELS*LW-1:0] w_rdata;

  // A ctrl_in beat always (re)starts at beat 0; otherwise continue an active frame
  always_comb begin
    w_beat = ctrl_in | r_wactive;
    w_idx  = ctrl_in ? '0 : r_wcnt;
    w_mode = ctrl_in ? mode_in : r_wmode;
    w_last = w_beat && (w_idx == LAST_BEAT);
  end

  // Point addresses for the beat being written and the beat being read
  always_comb begin
    for (int l = 0; l < NUM_CHANNELS; l++) begin
      w_waddr[l] = LOG_F'(int'(w_idx) * NUM_CHANNELS + l);
      w_raddr[l] = perm_addr(r_rmode, LOG_F'(int'(r_rcnt) * NUM_CHANNELS + l));
    end
  end

  // Gather one output beat from the buffer being read
  always_comb begin
    w_rdata = '0;
    for (int l = 0; l < NUM_CHANNELS; l++) begin
      w_rdata[l*LW +: LW] = r_mem[r_rsel][w_raddr[l]];
    end
  end

  // Store every lane of an accepted input beat at its natural point index
  always_ff @(posedge clk) begin
    if (w_beat) begin
      for (int l = 0; l < NUM_CHANNELS; l++) begin
        r_mem[r_wsel][w_waddr[l]] <= in_data[l*LW +: LW];
      end
    end
  end

  // Write beat counter, captured mode and buffer swap on the last beat
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_wactive <= 1'b0;
      r_wcnt    <= '0;
      r_wmode   <= 2'd0;
      r_wsel    <= 1'b0;
    end else if (w_beat) begin
      r_wmode <= w_mode;
      if (w_last) begin
        r_wactive <= 1'b0;
        r_wcnt    <= '0;
        r_wsel    <= ~r_wsel;
      end else begin
        r_wactive <= 1'b1;
        r_wcnt    <= w_idx + CW'(1);
      end
    end
  end

  // Sticky restart error; a restart on the same edge as err_clr keeps it set
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      frame_err <= 1'b0;
    end else if (ctrl_in && r_wactive) begin
      frame_err <= 1'b1;
    end else if (err_clr) begin
      frame_err <= 1'b0;
    end
  end

  // Read sequencer: a completed frame starts reading the buffer just filled
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_ractive <= 1'b0;
      r_rcnt    <= '0;
      r_rmode   <= 2'd0;
      r_rsel    <= 1'b0;
    end else if (w_last) begin
      r_ractive <= 1'b1;
      r_rcnt    <= '0;
      r_rmode   <= w_mode;
      r_rsel    <= r_wsel;
    end else if (r_ractive) begin
      if (r_rcnt == LAST_BEAT) begin
        r_ractive <= 1'b0;
        r_rcnt    <= '0;
      end else begin
        r_rcnt <= r_rcnt + CW'(1);
      end
    end
  end

  // Registered outputs; data forced to zero outside valid beats
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      out_data  <= '0;
      ctrl_out  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= r_ractive;
      ctrl_out  <= r_ractive && (r_rcnt == '0);
      out_data  <= r_ractive ? w_rdata : '0;
    end
  end

endmodule

// File: tb/tb_stride_perm_bank.sv
// tb/tb_stride_perm_bank.sv - directed self-checking bench for stride_perm_bank
module tb_stride_perm_bank;

  logic         clk = 1'b0;
  logic         rst_in;
  logic [127:0] in_data;
  logic         ctrl_in;
  logic [1:0]   mode_in;
  logic         err_clr;
  logic [127:0] out_data;
  logic         ctrl_out;
  logic         out_valid;
  logic         frame_err;

  int checks = 0;
  int errors = 0;
  logic [127:0] got [16];

  stride_perm_bank #(.DATA_WIDTH(16), .NUM_CHANNELS(4), .FRAME_LEN(64)) dut (
    .clk(clk), .rst_in(rst_in), .in_data(in_data), .ctrl_in(ctrl_in),
    .mode_in(mode_in), .err_clr(err_clr), .out_data(out_data),
    .ctrl_out(ctrl_out), .out_valid(out_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pt(input int p);
    return {16'(p), 16'(16'h0100 + p)};
  endfunction

  function automatic logic [127:0] lanes4(input int a, input int b, input int c, input int d);
    return {pt(d), pt(c), pt(b), pt(a)};
  endfunction

  function automatic int perm(input int mode, input int q);
    int r;
    r = 0;
    if (mode == 1) begin
      r = (q % 16) * 4 + q / 16;
    end else if (mode == 2) begin
      for (int i = 0; i < 6; i++) if (((q >> i) & 1) != 0) r = r | (1 << (5 - i));
    end else begin
      r = q;
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_beat(input int mode, input int k);
    return lanes4(perm(mode, 4*k), perm(mode, 4*k+1), perm(mode, 4*k+2), perm(mode, 4*k+3));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [1:0] m, input int b);
    ctrl_in = c;
    mode_in = m;
    in_data = lanes4(4*b, 4*b+1, 4*b+2, 4*b+3);
    tick();
  endtask

  task automatic idle_tick();
    ctrl_in = 1'b0;
    mode_in = 2'($urandom);
    in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
  endtask

  task automatic chk_out(input string tag, input int mode, input int k);
    chk({tag, "_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_ctrl"}, 128'(ctrl_out), 128'(k == 0));
    chk({tag, "_data"}, out_data, exp_beat(mode, k));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_ctrl"}, 128'(ctrl_out), 128'(0));
    chk({tag, "_data"}, out_data, 128'(0));
  endtask

  task automatic send_frame(input logic [1:0] m);
    for (int b = 0; b < 16; b++) drive(b == 0, m, b);
  endtask

  task automatic drain(input string tag, input int mode);
    for (int k = 0; k < 16; k++) begin
      idle_tick();
      chk_out(tag, mode, k);
      got[k] = out_data;
    end
  endtask

  initial begin
    rst_in = 1'b0; ctrl_in = 1'b0; mode_in = 2'd0; err_clr = 1'b0; in_data = '0;

    for (int i = 0; i < 4; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      ctrl_in = 1'($urandom);
      mode_in = 2'($urandom);
      tick();
      chk_idle("rst");
      chk("rst_err", 128'(frame_err), 128'(0));
    end
    ctrl_in = 1'b0;
    rst_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle_tick();
      chk("post_rst_valid", 128'(out_valid), 128'(0));
    end

    send_frame(2'd0);
    chk("m0_latency", 128'(out_valid), 128'(0));
    drain("m0", 0);
    idle_tick();
    chk_idle("m0_post");

    send_frame(2'd1);
    drain("m1", 1);
    chk("m1_b0", got[0], lanes4(0, 4, 8, 12));
    chk("m1_b4", got[4], lanes4(1, 5, 9, 13));
    chk("m1_b15", got[15], lanes4(51, 55, 59, 63));
    idle_tick();
    chk_idle("m1_post");

    send_frame(2'd2);
    drain("m2", 2);
    chk("m2_b0", got[0], lanes4(0, 32, 16, 48));
    chk("m2_b1", got[1], lanes4(8, 40, 24, 56));
    idle_tick();
    chk_idle("m2_post");

    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 16; b++) begin
        drive(b == 0, 2'(f), b);
        if (f > 0) chk_out("b2b", f - 1, b);
        else chk("b2b_pre", 128'(out_valid), 128'(0));
      end
    end
    drain("b2b_last", 2);
    idle_tick();
    chk_idle("b2b_post");

    chk("err_init", 128'(frame_err), 128'(0));
    for (int b = 0; b < 7; b++) drive(b == 0, 2'd1, b);
    chk("err_before", 128'(frame_err), 128'(0));
    drive(1'b1, 2'd2, 0);
    chk("err_set", 128'(frame_err), 128'(1));
    for (int b = 1; b < 16; b++) begin
      drive(1'b0, 2'd0, b);
      chk("restart_no_out", 128'(out_valid), 128'(0));
    end
    drain("restart", 2);
    idle_tick();
    chk_idle("restart_post");
    chk("err_sticky", 128'(frame_err), 128'(1));
    err_clr = 1'b1;
    idle_tick();
    err_clr = 1'b0;
    chk("err_clr", 128'(frame_err), 128'(0));

    for (int b = 0; b < 3; b++) drive(b == 0, 2'd0, b);
    err_clr = 1'b1;
    drive(1'b1, 2'd1, 0);
    err_clr = 1'b0;
    chk("err_set_wins", 128'(frame_err), 128'(1));
    for (int b = 1; b < 9; b++) drive(1'b0, 2'd1, b);
    rst_in = 1'b0;
    in_data = lanes4(36, 37, 38, 39);
    #1;
    chk_idle("async_rst");
    chk("async_rst_err", 128'(frame_err), 128'(0));
    tick();
    rst_in = 1'b1;
    for (int b = 10; b < 16; b++) drive(1'b0, 2'd1, b);
    for (int i = 0; i < 30; i++) begin
      idle_tick();
      chk("rst_discard", 128'(out_valid), 128'(0));
    end

    send_frame(2'd3);
    drain("m3", 3);
    chk("m3_b5", got[5], lanes4(20, 21, 22, 23));
    idle_tick();
    chk_idle("m3_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
